instr_fetch_queue: RTL and testbench

//  Fetch-side initiator for the 1024x32 instruction memory: drives the word address, captures the returned

---
 rtl/instr_fetch_queue.sv | 116 +++++++++++
 tb/tb_instr_fetch_queue.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// ----------------------------------------------------------------------------
// instr_fetch_queue
//   Fetch-side initiator for the instruction memory. It drives the word
//   address for the current fetch PC and captures the instruction returned in
//   the same cycle. Each {pc, instr} pair is buffered in a small FIFO that
//   feeds the decode stage. A redirect flushes the queue and restarts fetch at
//   the new PC.
//
// Ports
//   clk, rst_n          clock / asynchronous active-low reset
//   fetch_en            fetch allowed this cycle
//   redirect_valid/_pc  flush the queue, restart fetch at redirect_pc (word aligned)
//   imem_addr           word address presented to instruction memory
//   imem_instruction    instruction memory data for imem_addr (same cycle)
//   out_valid/_ready    head handshake toward decode
//   out_instr, out_pc   head entry contents
//   queue_level         number of entries held
// ----------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          ADDR_W   = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_en,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [31:0]                imem_instruction,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    output logic [$clog2(DEPTH):0]     queue_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DEPTH-1:0][31:0] pc_q;
    logic [DEPTH-1:0][31:0] instr_q;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [31:0]            fetch_pc_q, fetch_pc_d;

    logic full, push, pop;

    // Redirect masks the head immediately so decode never consumes a
    // wrong-path instruction in the flush cycle.
    assign out_valid = (level_q != '0) & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    assign full      = (level_q == LVL_W'(DEPTH));
    // A full queue can still accept a word when the head leaves in the same cycle.
    assign push      = fetch_en & ~redirect_valid & (~full | pop);

    assign imem_addr   = fetch_pc_q[ADDR_W+1:2];
    assign out_instr   = instr_q[rd_ptr_q];
    assign out_pc      = pc_q[rd_ptr_q];
    assign queue_level = level_q;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        fetch_pc_d = fetch_pc_q;

        if (redirect_valid) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            level_d    = '0;
            fetch_pc_d = redirect_pc & ~32'h3;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            fetch_pc_q <= RESET_PC;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // When full with a pop, wr_ptr equals rd_ptr: the departing head slot is
    // overwritten at the same edge it is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= '0;
        end else if (push) begin
            pc_q[wr_ptr_q]    <= fetch_pc_q;
            instr_q[wr_ptr_q] <= imem_instruction;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_queue
//   Directed bench for instr_fetch_queue. The memory model returns
//   32'h1000_0000 + word address, so every expected instruction follows from
//   its PC.
// ----------------------------------------------------------------------------
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [9:0]  imem_addr;
    logic [31:0] imem_instruction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  queue_level;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .ADDR_W(10)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_en         (fetch_en),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_addr        (imem_addr),
        .imem_instruction (imem_instruction),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_pc           (out_pc),
        .queue_level      (queue_level)
    );

    always #5 clk = ~clk;

    assign imem_instruction = 32'h1000_0000 + {22'b0, imem_addr};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Head entry check: valid, pc, matching instruction, level.
    task automatic chk_head(input string tag, input logic [31:0] pc, input int lvl);
        chk({tag, ".vld"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ".pc"},  out_pc, pc);
        chk({tag, ".ins"}, out_instr, 32'h1000_0000 + {22'b0, pc[11:2]});
        chk({tag, ".lvl"}, {29'b0, queue_level}, lvl);
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        #2;
        // Reset state
        chk("rst.vld",  {31'b0, out_valid}, 32'd0);
        chk("rst.pc",   out_pc, 32'h0);
        chk("rst.ins",  out_instr, 32'h0);
        chk("rst.lvl",  {29'b0, queue_level}, 32'd0);
        chk("rst.addr", {22'b0, imem_addr}, 32'h0);
        #10;
        rst_n     = 1'b1;
        fetch_en  = 1'b1;
        out_ready = 1'b1;

        // Streaming: one instruction per cycle from the first edge
        for (int k = 0; k < 6; k++) begin
            step();
            chk_head("stream", 32'(4 * k), 1);
            chk("stream.addr", {22'b0, imem_addr}, 32'(k + 1));
        end
        // head 0x14, fetch_pc 0x18

        // Back-pressure: fills to 4 then fetch stalls
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) step();
        chk_head("stall", 32'h14, 4);
        chk("stall.addr", {22'b0, imem_addr}, 32'h9);

        // Full with ready every cycle: level stays 4, order intact
        out_ready = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            step();
            chk_head("full_stream", 32'h14 + 32'(4 * j), 4);
        end
        chk("full_stream.addr", {22'b0, imem_addr}, 32'hF);

        // fetch_en low: pops continue, fetch_pc holds
        fetch_en = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            step();
            chk_head("nofetch", 32'h2C + 32'(4 * j), 4 - j);
            chk("nofetch.addr", {22'b0, imem_addr}, 32'hF);
        end

        // Refill to full: queue 0x38..0x44, fetch_pc 0x48
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) step();
        chk_head("refill", 32'h38, 4);
        chk("refill.addr", {22'b0, imem_addr}, 32'h12);

        // Redirect while full: head masked the same cycle
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        chk("redir.vld0", {31'b0, out_valid}, 32'd0);
        step();
        chk("redir.lvl", {29'b0, queue_level}, 32'd0);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        #1;
        chk("redir.vld1", {31'b0, out_valid}, 32'd0);
        chk("redir.addr", {22'b0, imem_addr}, 32'h40);
        step();
        chk_head("redir.first", 32'h100, 1);

        // Address wrap: word address wraps, byte PC does not
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0FFC;
        step();
        redirect_valid = 1'b0;
        chk("wrap.lvl",   {29'b0, queue_level}, 32'd0);
        chk("wrap.addr0", {22'b0, imem_addr}, 32'h3FF);
        step();
        chk("wrap.pc0",   out_pc, 32'hFFC);
        chk("wrap.ins0",  out_instr, 32'h1000_03FF);
        chk("wrap.addr1", {22'b0, imem_addr}, 32'h000);
        step();
        chk("wrap.pc1",   out_pc, 32'h1000);
        chk("wrap.ins1",  out_instr, 32'h1000_0000);
        chk("wrap.addr2", {22'b0, imem_addr}, 32'h001);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.vld",  {31'b0, out_valid}, 32'd0);
        chk("areset.pc",   out_pc, 32'h0);
        chk("areset.ins",  out_instr, 32'h0);
        chk("areset.lvl",  {29'b0, queue_level}, 32'd0);
        chk("areset.addr", {22'b0, imem_addr}, 32'h0);
        #1;
        rst_n = 1'b1;
        step();
        chk_head("restart0", 32'h0, 1);
        step();
        chk_head("restart1", 32'h4, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
